// File: rtl/mult_booth_seq.sv
// Iterative signed WIDTH x WIDTH Booth multiplier with start/ready handshake.
// Define MULT_RADIX4_EN for modified-Booth radix-4 (WIDTH/2 iterations).
module mult_booth_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned AW = WIDTH + 2;
`ifdef MULT_RADIX4_EN
  localparam int unsigned ITERS = WIDTH / 2;
`else
  localparam int unsigned ITERS = WIDTH;
`endif
  localparam int unsigned CW = unsigned'($clog2(ITERS + 1));
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, exc_d;
  logic             rdy_q, busy_q;
  logic             iter_c, finish_c;
  logic [AW-1:0]    m_ext, addend, sum;
  logic [WIDTH:0]   top_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a start in any state restarts the operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ctrl_MULT) state_d = RUN;
  end

  // Datapath control decode
  always_comb begin
    iter_c   = 1'b0;
    finish_c = 1'b0;
    if (state_q == RUN && !ctrl_MULT) begin
      iter_c   = 1'b1;
      finish_c = (count_q == LAST);
    end
  end

  // One Booth step: add/subtract multiple of M, then arithmetic shift right
  always_comb begin
    m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
    addend = '0;
`ifdef MULT_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = AW'(m_ext << 1);
      3'b100:         addend = AW'(-(m_ext << 1));
      3'b101, 3'b110: addend = AW'(-m_ext);
      default:        addend = '0;
    endcase
    sum   = acc_q + addend;
    acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_d   = {sum[1:0], q_q[WIDTH-1:2]};
    qm1_d = q_q[1];
`else
    case ({q_q[0], qm1_q})
      2'b01:   addend = m_ext;
      2'b10:   addend = AW'(-m_ext);
      default: addend = '0;
    endcase
    sum   = acc_q + addend;
    acc_d = {sum[AW-1], sum[AW-1:1]};
    q_d   = {sum[0], q_q[WIDTH-1:1]};
    qm1_d = q_q[0];
`endif
    // Product fits in WIDTH signed bits only if the upper half matches the result sign
    top_c = {acc_d[WIDTH-1:0], q_d[WIDTH-1]};
    exc_d = ~((&top_c) | ~(|top_c));
  end

  // Product register, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q  <= (state_d == DONE);
      busy_q <= (state_d == RUN);
      if (ctrl_MULT) begin
        count_q  <= '0;
        acc_q    <= '0;
        m_q      <= data_operandA;
        q_q      <= data_operandB;
        qm1_q    <= 1'b0;
        result_q <= '0;
        exc_q    <= 1'b0;
      end else if (iter_c) begin
        count_q <= count_q + CW'(1);
        acc_q   <= acc_d;
        q_q     <= q_d;
        qm1_q   <= qm1_d;
        if (finish_c) begin
          result_q <= q_d;
          exc_q    <= exc_d;
        end
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Scoreboard bench for mult_booth_seq: reference products queued at start, checked on RDY.
module tb_mult_booth_seq;

`ifdef MULT_RADIX4_EN
  localparam int ITERS = 16;
`else
  localparam int ITERS = 32;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
    int          bsnap;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy_total = 0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  mult_booth_seq #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy) busy_total++;
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          check_eq("spurious_rdy", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("result", {32'd0, data_result}, {32'd0, e.res});
          check_eq("exception", {63'd0, data_exception}, {63'd0, e.exc});
          check_eq("latency", 64'(cyc - e.cyc), 64'(ITERS));
          check_eq("busy_cycles", 64'(busy_total - e.bsnap), 64'(ITERS));
          last_res = e.res;
          last_exc = e.exc;
        end
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] p;
    @(negedge clk);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clk);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    e.res   = p[31:0];
    e.exc   = (p != {{32{p[31]}}, p[31:0]});
    e.cyc   = cyc;
    e.bsnap = busy_total;
    sb.push_back(e);
    check_eq("start_clr", {31'd0, data_exception, data_result}, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_out", {29'd0, busy, data_resultRDY, data_exception, data_result}, 64'd0);
    reset = 1'b0;

    start_op(32'd7, 32'd6);
    drain();
    repeat (3) @(negedge clk);
    check_eq("hold", {31'd0, data_exception, data_result}, {31'd0, last_exc, last_res});
    start_op(32'hFFFF_FFFD, 32'd5);
    drain();
    start_op(32'h7FFF_FFFF, 32'd2);
    drain();
    start_op(32'h8000_0000, 32'h8000_0000);
    drain();
    start_op(32'h8000_0000, 32'd1);
    drain();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    start_op(32'h0001_0000, 32'h0000_8000);
    drain();
    start_op(32'h0001_0000, 32'hFFFF_8000);
    drain();
    for (int i = 0; i < 16; i++) begin
      start_op($urandom, (i < 8) ? 32'($urandom_range(0, 65535)) : 32'($urandom));
      drain();
    end

    // Restart mid-operation: only the second product must appear
    start_op(32'd3, 32'd3);
    repeat (10) @(posedge clk);
    start_op(32'd4, 32'd5);
    drain();

    // Reset mid-operation: outputs clear and no RDY follows
    start_op(32'h1234_5678, 32'h0BAD_F00D);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_reset", {29'd0, busy, data_resultRDY, data_exception, data_result}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (ITERS + 5) @(negedge clk);
    check_eq("post_reset_idle", {62'd0, busy, data_resultRDY}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
